// File: rtl/main_memory_model.sv
// rtl/main_memory_model.sv - word-organised backing store behind the L1 cache with fixed access latency
// Request/acknowledge handshake with latched operands and read/write completion counters.
module main_memory_model #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Mem_Request,
    input  logic                  MEM_WE,
    input  logic [ADDR_WIDTH-1:0] Mem_Address,
    input  logic [DATA_WIDTH-1:0] Mem_WData,
    output logic [DATA_WIDTH-1:0] Mem_RData,
    output logic                  MEM_ACK,
    output logic                  Mem_Busy,
    output logic [31:0]           Read_Count,
    output logic [31:0]           Write_Count
);
    localparam int       DEPTH  = 1 << DEPTH_LOG2;
    localparam bit [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ACK} state_t;

    state_t                  r_state;
    logic [7:0]              r_count;
    logic                    r_we;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_ack;
    logic [31:0]             r_rd_cnt;
    logic [31:0]             r_wr_cnt;
    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1] = '{default: '0};

    logic                    w_access;
    logic                    w_unused;

    // Byte-offset bits and address bits above the array size alias away.
    assign w_unused = ^{Mem_Address[1:0], Mem_Address[ADDR_WIDTH-1:DEPTH_LOG2+2]};

    assign w_access = !rst && (r_state == ST_BUSY) && Mem_Request && (r_count == 8'd0);

    always_ff @(posedge clk) begin
        if (w_access && r_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_count  <= 8'd0;
            r_we     <= 1'b0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_ack    <= 1'b0;
            r_rd_cnt <= 32'd0;
            r_wr_cnt <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Mem_Request) begin
                        r_we    <= MEM_WE;
                        r_idx   <= Mem_Address[DEPTH_LOG2+1:2];
                        r_wdata <= Mem_WData;
                        r_count <= LAT_M1;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!Mem_Request) begin
                        r_state <= ST_IDLE;
                    end else if (r_count == 8'd0) begin
                        if (r_we) begin
                            r_wr_cnt <= r_wr_cnt + 32'd1;
                        end else begin
                            r_rdata  <= r_mem[r_idx];
                            r_rd_cnt <= r_rd_cnt + 32'd1;
                        end
                        r_ack   <= 1'b1;
                        r_state <= ST_ACK;
                    end else begin
                        r_count <= r_count - 8'd1;
                    end
                end
                ST_ACK: begin
                    if (!Mem_Request) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Mem_RData   = r_rdata;
    assign MEM_ACK     = r_ack;
    assign Mem_Busy    = (r_state != ST_IDLE);
    assign Read_Count  = r_rd_cnt;
    assign Write_Count = r_wr_cnt;
endmodule

// File: tb/tb_main_memory_model.sv
// tb/tb_main_memory_model.sv - scoreboard bench for main_memory_model at LATENCY 4 and LATENCY 1
module tb_main_memory_model;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_req, a_we, a_ack, a_busy;
    logic [31:0] a_addr, a_wdata, a_rdata, a_rc, a_wc;
    logic        b_req, b_we, b_ack, b_busy;
    logic [31:0] b_addr, b_wdata, b_rdata, b_rc, b_wc;

    main_memory_model #(.LATENCY(4)) dut_a (
        .clk(clk), .rst(rst), .Mem_Request(a_req), .MEM_WE(a_we),
        .Mem_Address(a_addr), .Mem_WData(a_wdata), .Mem_RData(a_rdata),
        .MEM_ACK(a_ack), .Mem_Busy(a_busy), .Read_Count(a_rc), .Write_Count(a_wc)
    );

    main_memory_model #(.LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .Mem_Request(b_req), .MEM_WE(b_we),
        .Mem_Address(b_addr), .Mem_WData(b_wdata), .Mem_RData(b_rdata),
        .MEM_ACK(b_ack), .Mem_Busy(b_busy), .Read_Count(b_rc), .Write_Count(b_wc)
    );

    typedef struct {
        logic [31:0] data;
        int          lat;
        logic [31:0] rc;
        logic [31:0] wc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl_a [0:4095];
    logic [31:0] mdl_b [0:4095];
    logic [31:0] last_a, last_b, rc_a, wc_a, rc_b, wc_b;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic txn(input bit sel, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input bit rst_in_ack);
        exp_t       e;
        int         n;
        logic [11:0] idx;
        idx   = addr[13:2];
        e.lat = sel ? 1 : 4;
        if (!sel) begin
            if (we) begin mdl_a[idx] = wd; wc_a++; end
            else begin last_a = mdl_a[idx]; rc_a++; end
            e.data = last_a; e.rc = rc_a; e.wc = wc_a;
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end else begin
            if (we) begin mdl_b[idx] = wd; wc_b++; end
            else begin last_b = mdl_b[idx]; rc_b++; end
            e.data = last_b; e.rc = rc_b; e.wc = wc_b;
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end
        sb.push_back(e);
        @(posedge clk); #1;
        chk("busy_after_accept", sel ? b_busy : a_busy, 1);
        // Operands wander after acceptance; the DUT must use its latched copy.
        if (!sel) begin a_we = ~we; a_addr = addr ^ 32'h0000_0FF0; a_wdata = ~wd; end
        else      begin b_we = ~we; b_addr = addr ^ 32'h0000_0FF0; b_wdata = ~wd; end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(sel ? b_ack : a_ack) && n < 50);
        e = sb.pop_front();
        chk("ack_latency", n, e.lat);
        chk("rdata", sel ? b_rdata : a_rdata, e.data);
        chk("read_count", sel ? b_rc : a_rc, e.rc);
        chk("write_count", sel ? b_wc : a_wc, e.wc);
        if (rst_in_ack) begin
            rst = 1'b1;
            @(posedge clk); #1;
            chk("rst_ack", sel ? b_ack : a_ack, 0);
            chk("rst_busy", sel ? b_busy : a_busy, 0);
            chk("rst_rdata", sel ? b_rdata : a_rdata, 0);
            chk("rst_rc", sel ? b_rc : a_rc, 0);
            chk("rst_wc", sel ? b_wc : a_wc, 0);
            rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
            last_a = 0; rc_a = 0; wc_a = 0;
            last_b = 0; rc_b = 0; wc_b = 0;
        end else begin
            @(posedge clk); #1;
            chk("ack_hold", sel ? b_ack : a_ack, 1);
            chk("rdata_hold", sel ? b_rdata : a_rdata, e.data);
            if (!sel) a_req = 1'b0; else b_req = 1'b0;
            @(posedge clk); #1;
            chk("ack_fall", sel ? b_ack : a_ack, 0);
            chk("idle_busy", sel ? b_busy : a_busy, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 4096; i++) begin mdl_a[i] = 0; mdl_b[i] = 0; end
        last_a = 0; rc_a = 0; wc_a = 0;
        last_b = 0; rc_b = 0; wc_b = 0;
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h0000_1234; a_wdata = 32'hDEAD_BEEF;
        b_req = 1'b0; b_we = 1'b0; b_addr = 0; b_wdata = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("reset_ack", a_ack, 0);
            chk("reset_busy", a_busy, 0);
            chk("reset_rdata", a_rdata, 0);
            chk("reset_rc", a_rc, 0);
            chk("reset_wc", a_wc, 0);
        end
        rst = 1'b0;

        txn(0, 1, 32'h0000_1234, 32'hDEAD_BEEF, 0);
        txn(0, 0, 32'h0000_1234, 32'h0, 0);
        txn(0, 1, 32'h0000_0008, 32'h1111_1111, 0);
        txn(0, 0, 32'h0000_400B, 32'h0, 0);

        // Request withdrawn two cycles into BUSY: no write, no ack.
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        chk("abort_busy", a_busy, 1);
        for (int i = 0; i < 2; i++) begin @(posedge clk); #1; end
        a_req = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle", a_busy, 0);
        for (int i = 0; i < 6; i++) begin
            chk("abort_no_ack", a_ack, 0);
            @(posedge clk); #1;
        end
        chk("abort_wc", a_wc, wc_a);
        txn(0, 0, 32'h20, 32'h0, 0);

        txn(1, 1, 32'h0000_0040, 32'hCAFE_F00D, 0);
        txn(1, 0, 32'h0000_0040, 32'h0, 0);
        txn(1, 0, 32'h0000_0040 ^ 32'h0000_0FF0, 32'h0, 0);

        for (int i = 0; i < 8; i++) begin
            txn(0, 1'($urandom_range(0, 1)), 32'($urandom_range(64, 127)) << 2, $urandom, 0);
        end

        txn(0, 0, 32'h0000_1234, 32'h0, 1);
        txn(0, 0, 32'h0000_1234, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
